// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : RISC-V style load/store unit. Accepts one request at a time
//               from the core, checks funct3 legality and alignment, runs a
//               single memory read or write handshake with a timeout, and
//               returns one response per accepted request.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, reset           : clock, asynchronous active-high reset
//   req_valid/req_ready  : core request handshake (ready only when idle)
//   req_write            : 1 = store, 0 = load
//   req_funct3           : RISC-V load/store funct3
//   req_addr, req_wdata  : byte address, store data
//   resp_valid           : one-cycle response pulse
//   resp_rdata           : extended load data (0 for stores and errors)
//   resp_err             : 00 ok, 01 misaligned, 10 timeout, 11 illegal funct3
//   mem_*                : memory read / write channels (all registered)
// ============================================================================
module load_store_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_err,
    output logic [31:0] mem_address,
    output logic        mem_read_enable,
    input  logic [31:0] mem_read_data,
    input  logic        mem_read_valid,
    output logic [31:0] mem_write_data,
    output logic        mem_write_enable,
    output logic [3:0]  mem_write_wstrb,
    input  logic        mem_write_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        ERR   = 2'd3
    } state_t;

    // Last counter value before the abort; the counter starts at 0 in the
    // first enable cycle, so TIMEOUT enable cycles elapse before aborting.
    localparam logic [7:0] C_CNT_LAST = 8'(TIMEOUT - 1);

    state_t      r_state, w_state_nxt;
    logic [7:0]  r_cnt, w_cnt_nxt;
    logic [2:0]  r_funct3, w_funct3_nxt;
    logic [1:0]  r_err_code, w_err_code_nxt;
    logic        r_req_ready, r_resp_valid, r_rd_en, r_wr_en;
    logic        w_resp_valid_nxt, w_rd_en_nxt, w_wr_en_nxt;
    logic [31:0] r_resp_rdata, r_addr, r_wdata;
    logic [31:0] w_resp_rdata_nxt, w_addr_nxt, w_wdata_nxt;
    logic [1:0]  r_resp_err, w_resp_err_nxt;
    logic [3:0]  r_wstrb, w_wstrb_nxt;
    logic        w_illegal, w_misaligned;
    logic [31:0] w_load_data;

    // Stores only allow 000..010; loads additionally allow 100/101.
    assign w_illegal = req_write ? (req_funct3[2] | (req_funct3[1:0] == 2'b11))
                                 : ((req_funct3 == 3'b011) | (req_funct3[2:1] == 2'b11));
    assign w_misaligned = ((req_funct3[1:0] == 2'b01) & req_addr[0]) |
                          ((req_funct3[1:0] == 2'b10) & (|req_addr[1:0]));

    always_comb begin
        w_load_data = mem_read_data;
        case (r_funct3)
            3'b000:  w_load_data = {{24{mem_read_data[7]}},  mem_read_data[7:0]};
            3'b001:  w_load_data = {{16{mem_read_data[15]}}, mem_read_data[15:0]};
            3'b100:  w_load_data = {24'd0, mem_read_data[7:0]};
            3'b101:  w_load_data = {16'd0, mem_read_data[15:0]};
            default: w_load_data = mem_read_data;
        endcase
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_funct3_nxt     = r_funct3;
        w_err_code_nxt   = r_err_code;
        w_resp_valid_nxt = 1'b0;
        w_resp_rdata_nxt = 32'd0;
        w_resp_err_nxt   = 2'b00;
        w_rd_en_nxt      = r_rd_en;
        w_wr_en_nxt      = r_wr_en;
        w_addr_nxt       = r_addr;
        w_wdata_nxt      = r_wdata;
        w_wstrb_nxt      = r_wstrb;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_cnt_nxt    = 8'd0;
                    w_funct3_nxt = req_funct3;
                    w_addr_nxt   = req_addr;
                    if (w_illegal) begin
                        w_state_nxt    = ERR;
                        w_err_code_nxt = 2'b11;
                    end else if (w_misaligned) begin
                        w_state_nxt    = ERR;
                        w_err_code_nxt = 2'b01;
                    end else if (req_write) begin
                        w_state_nxt = WRITE;
                        w_wr_en_nxt = 1'b1;
                        w_wdata_nxt = req_wdata;
                        case (req_funct3[1:0])
                            2'b00:   w_wstrb_nxt = 4'b0001;
                            2'b01:   w_wstrb_nxt = 4'b0011;
                            default: w_wstrb_nxt = 4'b1111;
                        endcase
                    end else begin
                        w_state_nxt = READ;
                        w_rd_en_nxt = 1'b1;
                    end
                end
            end
            READ: begin
                w_cnt_nxt = r_cnt + 8'd1;
                // A handshake in the final allowed cycle still wins.
                if (mem_read_valid) begin
                    w_state_nxt      = IDLE;
                    w_rd_en_nxt      = 1'b0;
                    w_resp_valid_nxt = 1'b1;
                    w_resp_rdata_nxt = w_load_data;
                end else if (r_cnt == C_CNT_LAST) begin
                    w_state_nxt      = IDLE;
                    w_rd_en_nxt      = 1'b0;
                    w_resp_valid_nxt = 1'b1;
                    w_resp_err_nxt   = 2'b10;
                end
            end
            WRITE: begin
                w_cnt_nxt = r_cnt + 8'd1;
                if (mem_write_ready) begin
                    w_state_nxt      = IDLE;
                    w_wr_en_nxt      = 1'b0;
                    w_resp_valid_nxt = 1'b1;
                end else if (r_cnt == C_CNT_LAST) begin
                    w_state_nxt      = IDLE;
                    w_wr_en_nxt      = 1'b0;
                    w_resp_valid_nxt = 1'b1;
                    w_resp_err_nxt   = 2'b10;
                end
            end
            default: begin
                w_state_nxt      = IDLE;
                w_resp_valid_nxt = 1'b1;
                w_resp_err_nxt   = r_err_code;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_cnt        <= 8'd0;
            r_funct3     <= 3'd0;
            r_err_code   <= 2'b00;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'd0;
            r_resp_err   <= 2'b00;
            r_rd_en      <= 1'b0;
            r_wr_en      <= 1'b0;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
            r_wstrb      <= 4'b0000;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_funct3     <= w_funct3_nxt;
            r_err_code   <= w_err_code_nxt;
            r_req_ready  <= (w_state_nxt == IDLE);
            r_resp_valid <= w_resp_valid_nxt;
            r_resp_rdata <= w_resp_rdata_nxt;
            r_resp_err   <= w_resp_err_nxt;
            r_rd_en      <= w_rd_en_nxt;
            r_wr_en      <= w_wr_en_nxt;
            r_addr       <= w_addr_nxt;
            r_wdata      <= w_wdata_nxt;
            r_wstrb      <= w_wstrb_nxt;
        end
    end

    assign req_ready        = r_req_ready;
    assign resp_valid       = r_resp_valid;
    assign resp_rdata       = r_resp_rdata;
    assign resp_err         = r_resp_err;
    assign mem_address      = r_addr;
    assign mem_read_enable  = r_rd_en;
    assign mem_write_enable = r_wr_en;
    assign mem_write_data   = r_wdata;
    assign mem_write_wstrb  = r_wstrb;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Self-checking bench for load_store_unit. Directed scenarios
//               plus random transactions, each compared against a reference
//               model computed from the load/store rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0, req_write = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
    logic        req_ready, resp_valid;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;
    logic [31:0] mem_address, mem_write_data;
    logic        mem_read_enable, mem_write_enable;
    logic [31:0] mem_read_data = 32'd0;
    logic        mem_read_valid = 1'b0, mem_write_ready = 1'b0;
    logic [3:0]  mem_write_wstrb;

    int n_cmp = 0;
    int n_fail = 0;

    load_store_unit #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_address(mem_address), .mem_read_enable(mem_read_enable),
        .mem_read_data(mem_read_data), .mem_read_valid(mem_read_valid),
        .mem_write_data(mem_write_data), .mem_write_enable(mem_write_enable),
        .mem_write_wstrb(mem_write_wstrb), .mem_write_ready(mem_write_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: response code, data, cycle of resp_valid (1 = first cycle
    // after accept) and number of cycles a memory enable is high. The
    // responder handshakes in cycle lat+1 of the access.
    function automatic void model(input logic wr, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [31:0] rdata,
                                  input int lat, output logic [1:0] err,
                                  output logic [31:0] rd, output int rcyc, output int ncyc);
        int b;
        int size;
        err = 2'b00; rd = 32'd0; rcyc = 2; ncyc = 0;
        if (wr ? (f3 > 3'd2) : (f3 == 3'd3 || f3 > 3'd5)) begin
            err = 2'b11; return;
        end
        size = 1 << f3[1:0];
        if ((addr % size) != 0) begin
            err = 2'b01; return;
        end
        if (lat + 1 > TO) begin
            err = 2'b10; rcyc = TO + 1; ncyc = TO; return;
        end
        rcyc = lat + 2; ncyc = lat + 1;
        if (!wr) begin
            case (f3)
                3'b000: begin b = int'(rdata & 32'hFF);   rd = (b >= 128)   ? 32'(b - 256)   : 32'(b); end
                3'b001: begin b = int'(rdata & 32'hFFFF); rd = (b >= 32768) ? 32'(b - 65536) : 32'(b); end
                3'b100: rd = rdata & 32'hFF;
                3'b101: rd = rdata & 32'hFFFF;
                default: rd = rdata;
            endcase
        end
    endfunction

    task automatic reset_outputs();
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_mem_address", mem_address, 32'd0);
        chk("rst_rd_en", 32'(mem_read_enable), 32'd0);
        chk("rst_wr_en", 32'(mem_write_enable), 32'd0);
        chk("rst_wdata", mem_write_data, 32'd0);
        chk("rst_wstrb", 32'(mem_write_wstrb), 32'd0);
    endtask

    // Called at a negedge; drives the request for one cycle.
    task automatic start(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rd);
        chk("req_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = wr; req_funct3 = f3;
        req_addr = addr; req_wdata = wd; mem_read_data = rd;
        @(negedge clk);
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
        req_funct3 = 3'($urandom); req_write = 1'($urandom);
    endtask

    // Plays the memory responder and returns at the negedge of the resp cycle.
    task automatic run(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] rd, input int lat,
                       input bit junk);
        logic [1:0]  e_err;
        logic [31:0] e_rd;
        logic [3:0]  strb;
        int e_cyc, e_en, cyc, en_cnt, bad;
        bit got;
        model(wr, f3, addr, rd, lat, e_err, e_rd, e_cyc, e_en);
        strb = 4'((1 << (1 << f3[1:0])) - 1);
        cyc = 1; en_cnt = 0; bad = 0; got = 0;
        while (!got && cyc <= TO + 4) begin
            if (resp_valid) begin
                got = 1;
                if (mem_read_enable || mem_write_enable) bad |= 16;
            end else begin
                if (mem_read_enable && mem_write_enable) bad |= 1;
                if (mem_read_enable || mem_write_enable) begin
                    en_cnt++;
                    if (mem_address !== addr) bad |= 2;
                    if (mem_write_enable !== wr) bad |= 4;
                    if (wr && (mem_write_data !== wd || mem_write_wstrb !== strb)) bad |= 8;
                end
                mem_read_valid  = !wr && (cyc == lat + 1);
                mem_write_ready =  wr && (cyc == lat + 1);
                if (junk) begin
                    req_valid = 1'($urandom); req_write = 1'($urandom);
                    req_funct3 = 3'($urandom); req_addr = $urandom;
                end
                @(negedge clk);
                cyc++;
            end
        end
        mem_read_valid = 1'b0; mem_write_ready = 1'b0; req_valid = 1'b0;
        chk("resp_seen", 32'(got), 32'd1);
        chk("resp_cycle", 32'(cyc), 32'(e_cyc));
        chk("resp_err", 32'(resp_err), 32'(e_err));
        chk("resp_rdata", resp_rdata, e_rd);
        chk("enable_cycles", 32'(en_cnt), 32'(e_en));
        chk("mem_side", 32'(bad), 32'd0);
    endtask

    // Response must be a single pulse; stray handshakes while idle are ignored.
    task automatic post(input bit force_hs);
        @(negedge clk);
        chk("one_pulse", 32'(resp_valid), 32'd0);
        mem_read_valid  = force_hs ? 1'b1 : 1'($urandom);
        mem_write_ready = force_hs ? 1'b1 : 1'($urandom);
        @(negedge clk);
        chk("idle_no_resp", 32'(resp_valid), 32'd0);
        chk("idle_ready", 32'(req_ready), 32'd1);
        chk("idle_no_en", 32'({mem_read_enable, mem_write_enable}), 32'd0);
        mem_read_valid = 1'b0; mem_write_ready = 1'b0;
    endtask

    initial begin
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr, wd, rd;
        int          lat;

        #2 reset = 1'b1;
        #1 reset_outputs();
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(req_ready), 32'd1);

        // lb sign extension
        start(1'b0, 3'b000, 32'h103, 32'd0, 32'h0000_00F0);
        chk("lb_c1_addr", mem_address, 32'h103);
        chk("lb_c1_rd_en", 32'(mem_read_enable), 32'd1);
        run(1'b0, 3'b000, 32'h103, 32'd0, 32'h0000_00F0, 1, 1'b0);
        post(1'b0);

        // sh strobe and unshifted data
        start(1'b1, 3'b001, 32'h200, 32'h1234_ABCD, 32'd0);
        run(1'b1, 3'b001, 32'h200, 32'h1234_ABCD, 32'd0, 1, 1'b0);
        post(1'b0);

        // misaligned lw, illegal load funct3, illegal beats misaligned
        start(1'b0, 3'b010, 32'h102, 32'd0, 32'd0);
        run(1'b0, 3'b010, 32'h102, 32'd0, 32'd0, 0, 1'b0);
        post(1'b0);
        start(1'b0, 3'b011, 32'h100, 32'd0, 32'd0);
        run(1'b0, 3'b011, 32'h100, 32'd0, 32'd0, 3, 1'b0);
        post(1'b0);
        start(1'b1, 3'b111, 32'h101, 32'd0, 32'd0);
        run(1'b1, 3'b111, 32'h101, 32'd0, 32'd0, 0, 1'b0);
        post(1'b0);

        // lhu timeout with a late read_valid; handshake on the last allowed cycle
        start(1'b0, 3'b101, 32'h202, 32'd0, 32'h0000_8001);
        run(1'b0, 3'b101, 32'h202, 32'd0, 32'h0000_8001, 30, 1'b0);
        post(1'b1);
        start(1'b0, 3'b001, 32'h206, 32'd0, 32'h0000_8001);
        run(1'b0, 3'b001, 32'h206, 32'd0, 32'h0000_8001, TO - 1, 1'b0);
        post(1'b0);

        // back-to-back sw then lbu
        start(1'b1, 3'b010, 32'h300, 32'hCAFE_F00D, 32'd0);
        run(1'b1, 3'b010, 32'h300, 32'hCAFE_F00D, 32'd0, 1, 1'b0);
        start(1'b0, 3'b100, 32'h305, 32'd0, 32'h0000_0080);
        run(1'b0, 3'b100, 32'h305, 32'd0, 32'h0000_0080, 1, 1'b0);
        post(1'b0);

        // reset during READ, then a normal lw
        start(1'b0, 3'b010, 32'h400, 32'd0, 32'h1111_2222);
        @(negedge clk);
        chk("pre_rst_rd_en", 32'(mem_read_enable), 32'd1);
        #2 reset = 1'b1;
        #1 reset_outputs();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("abandon_no_resp", 32'(resp_valid), 32'd0);
        start(1'b0, 3'b010, 32'h404, 32'd0, 32'h8765_4321);
        run(1'b0, 3'b010, 32'h404, 32'd0, 32'h8765_4321, 1, 1'b0);
        post(1'b0);

        // random traffic; every fourth transaction chains back-to-back
        for (int i = 0; i < 40; i++) begin
            wr   = 1'($urandom);
            f3   = 3'($urandom);
            addr = $urandom;
            wd   = $urandom;
            rd   = $urandom;
            if ($urandom_range(0, 2) != 0) addr[1:0] = 2'b00;
            lat  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(4, 20))
                                               : int'($urandom_range(0, 3));
            start(wr, f3, addr, wd, rd);
            run(wr, f3, addr, wd, rd, lat, 1'b1);
            if (i % 4 != 3) post(1'b0);
        end
        post(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, the maximum cycles to wait for mem_read_valid/mem_write_ready before aborting (range 2..255).
REQ-002 SHALL have ports: clk input 1 system clock; reset input 1 asynchronous active-high reset.
REQ-003 SHALL have core-side ports: req_valid in 1; req_ready out 1; req_write in 1 (1=store); req_funct3 in 3 (RISC-V load/store funct3); req_addr in 32 byte address; req_wdata in 32 store data.
REQ-004 SHALL have response ports: resp_valid out 1 (one-cycle pulse); resp_rdata out 32 extended load data; resp_err out 2 (00 ok, 01 misaligned, 10 timeout, 11 illegal funct3).
REQ-005 SHALL have memory-side ports: mem_address out 32; mem_read_enable out 1; mem_read_data in 32; mem_read_valid in 1; mem_write_data out 32; mem_write_enable out 1; mem_write_wstrb out 4; mem_write_ready in 1.
REQ-006 SHALL treat the clock as one clock clk and the reset as asynchronous, active-high reset; all outputs registered.

Function
REQ-007 SHALL implement states IDLE, READ, WRITE, ERR; req_ready = 1 only in IDLE.
REQ-008 SHALL accept a request in a cycle where req_valid & req_ready; latch addr, wdata, funct3, write on that edge.
REQ-009 Legal loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; legal stores: 000 sb, 001 sh, 010 sw; others -> ERR with code 11.
REQ-010 Misaligned: halfword with addr[0]=1, word with addr[1:0]!=00 -> ERR with code 01; illegal-funct3 check takes priority.
REQ-011 ERR: no memory enable asserted; next cycle resp_valid=1, resp_err as latched, resp_rdata=0; return to IDLE.
REQ-012 READ: mem_read_enable=1 from cycle after accept, held until the edge after mem_read_valid is sampled high; mem_address held stable throughout.
REQ-013 WRITE: mem_write_enable=1 likewise until the edge after mem_write_ready; mem_write_data = req_wdata unshifted; wstrb sb 0001, sh 0011, sw 1111.
REQ-014 Nominal latency with single-cycle responder: accept C0, enable C1, valid/ready C2, resp_valid C3 with enable low in C3.
REQ-015 Load extraction from mem_read_data[7:0]/[15:0]/[31:0]: lb/lh sign-extend, lbu/lhu zero-extend, lw direct; store resp_rdata=0.
REQ-016 Timeout counter clears on accept, increments each cycle in READ/WRITE; at count TIMEOUT without handshake, drop enable, pulse resp_valid with resp_err=10, rdata=0, return to IDLE.
REQ-017 Handshake in same cycle the counter reaches TIMEOUT SHALL count as success.
REQ-018 mem_read_valid/mem_write_ready while IDLE or ERR SHALL be ignored (no response, no state change).
REQ-019 Back-to-back: a request accepted in the resp_valid cycle SHALL start its access next cycle; exactly one response per accepted request.
REQ-020 mem_read_enable and mem_write_enable SHALL never be high together.
REQ-021 Request inputs SHALL be ignored when req_ready=0.

Reset
REQ-022 On reset assertion, immediately: state IDLE, req_ready=1 after release, resp_valid=0, resp_rdata=0, resp_err=00, mem_address=0, mem_read_enable=0, mem_write_enable=0, mem_write_data=0, mem_write_wstrb=0000, counter=0.
REQ-023 Reset mid-access SHALL abandon the transaction with no response; the first post-reset request behaves normally.

Verification
REQ-024 lb addr 0x103, mem_read_data=0x000000F0 -> C1 read_enable, address 0x103; C3 resp_rdata 0xFFFFFFF0, err 00.
REQ-025 sh addr 0x200, wdata 0x1234ABCD -> write_enable, wstrb 0011, write_data 0x1234ABCD; resp_valid two cycles after write_enable, rdata 0.
REQ-026 lw addr 0x102 -> no memory enable, resp_valid next cycle with err 01; funct3 011 load -> err 11.
REQ-027 lhu, responder silent, TIMEOUT=16 -> enable dropped, resp_valid err 10 sixteen cycles after enable; late read_valid ignored.
REQ-028 Back-to-back sw then lbu (read_data 0x80) -> second accepted in first resp cycle; responses in order, second rdata 0x00000080.
REQ-029 Reset asserted during READ -> all outputs zero asynchronously, no resp_valid; subsequent lw completes correctly.
